// File: rtl/branch_hazard_ctrl.sv
// ID-stage hazard controller: tracks EX/MEM/WB writers to produce stall and
// comparator forward selects, and owns the mult/div busy counter.
module branch_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_tuse_rs,
  input  logic [1:0] id_tuse_rt,
  input  logic [4:0] id_wa,
  input  logic [1:0] id_tnew,
  input  logic       id_is_md,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic       movzres,
  output logic       stall,
  output logic [1:0] fwd_d1,
  output logic [1:0] fwd_d2,
  output logic       md_busy
);

  logic [4:0]       ex_wa_q, mem_wa_q, wb_wa_q;
  logic [1:0]       ex_cnt_q, mem_cnt_q, wb_cnt_q;
  logic [4:0]       ex_wa_d;
  logic [1:0]       ex_cnt_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             data_stall;
  logic             md_stall;

  function automatic logic match(input logic [4:0] r, input logic [4:0] wa);
    return (r != '0) && (r == wa);
  endfunction

  // An operand stalls if its producer still needs more cycles than the
  // consumer can wait; tuse==3 marks an unused operand.
  function automatic logic hazard(input logic [4:0] r, input logic [1:0] tuse,
                                  input logic [4:0] wa, input logic [1:0] cnt);
    return (tuse != 2'd3) && match(r, wa) && (cnt > tuse);
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == '0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic [4:0] mem_wa, input logic [1:0] mem_cnt,
                                         input logic [4:0] wb_wa);
    if (match(r, mem_wa) && (mem_cnt == '0)) return 2'd1;
    else if (match(r, wb_wa))                return 2'd2;
    else                                     return 2'd0;
  endfunction

  always_comb begin
    data_stall = hazard(id_rs, id_tuse_rs, ex_wa_q,  ex_cnt_q)
               | hazard(id_rs, id_tuse_rs, mem_wa_q, mem_cnt_q)
               | hazard(id_rs, id_tuse_rs, wb_wa_q,  wb_cnt_q)
               | hazard(id_rt, id_tuse_rt, ex_wa_q,  ex_cnt_q)
               | hazard(id_rt, id_tuse_rt, mem_wa_q, mem_cnt_q)
               | hazard(id_rt, id_tuse_rt, wb_wa_q,  wb_cnt_q);
    md_stall   = id_is_md && md_busy;
    stall      = id_valid && (data_stall || md_stall);
    fwd_d1     = fwd_sel(id_rs, mem_wa_q, mem_cnt_q, wb_wa_q);
    fwd_d2     = fwd_sel(id_rt, mem_wa_q, mem_cnt_q, wb_wa_q);
  end

  // A cancelled movz enters EX as a bubble so it never matches a later reader.
  always_comb begin
    ex_wa_d  = '0;
    ex_cnt_d = '0;
    if (id_valid && !stall && !movzres) begin
      ex_wa_d  = id_wa;
      ex_cnt_d = id_tnew;
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (id_valid && id_md_start && !stall)
      md_cnt_d = id_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_wa_q   <= '0;
      ex_cnt_q  <= '0;
      mem_wa_q  <= '0;
      mem_cnt_q <= '0;
      wb_wa_q   <= '0;
      wb_cnt_q  <= '0;
      md_cnt_q  <= '0;
    end else begin
      ex_wa_q   <= ex_wa_d;
      ex_cnt_q  <= ex_cnt_d;
      mem_wa_q  <= ex_wa_q;
      mem_cnt_q <= sat_dec(ex_cnt_q);
      wb_wa_q   <= mem_wa_q;
      wb_cnt_q  <= sat_dec(mem_cnt_q);
      md_cnt_q  <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed pipeline scenarios followed by
// random traffic, all checked against an age-based writer/busy-time model.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wa;
  logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
  logic       id_is_md, id_md_start, id_md_div, movzres;
  logic       stall, md_busy;
  logic [1:0] fwd_d1, fwd_d2;

  branch_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_wa(id_wa), .id_tnew(id_tnew),
    .id_is_md(id_is_md), .id_md_start(id_md_start), .id_md_div(id_md_div),
    .movzres(movzres), .stall(stall), .fwd_d1(fwd_d1), .fwd_d2(fwd_d2), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Writers by age since entering EX (0=EX, 1=MEM, 2=WB); result is ready
  // once age >= tnew. Mult/div busy is tracked as an absolute end cycle.
  int     hw[3];
  int     ht[3];
  longint cyc = 0;
  longint busy_until = 0;
  int     m_stall, m_f1, m_f2, m_busy;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int remaining(input int a);
    return (ht[a] - a > 0) ? ht[a] - a : 0;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin
      hw[a] = 0;
      ht[a] = 0;
    end
    busy_until = 0;
  endtask

  task automatic model_eval();
    int rr[2];
    int tu[2];
    int sel[2];
    bit ds;
    rr[0] = int'(id_rs);      rr[1] = int'(id_rt);
    tu[0] = int'(id_tuse_rs); tu[1] = int'(id_tuse_rt);
    m_busy = (busy_until > cyc) ? 1 : 0;
    ds = 0;
    for (int k = 0; k < 2; k++) begin
      if (tu[k] != 3)
        for (int a = 0; a < 3; a++)
          if (rr[k] != 0 && rr[k] == hw[a] && remaining(a) > tu[k]) ds = 1;
      sel[k] = 0;
      if (rr[k] != 0 && rr[k] == hw[1] && remaining(1) == 0) sel[k] = 1;
      else if (rr[k] != 0 && rr[k] == hw[2])                 sel[k] = 2;
    end
    m_stall = (id_valid && (ds || (id_is_md && m_busy != 0))) ? 1 : 0;
    m_f1 = sel[0];
    m_f2 = sel[1];
  endtask

  task automatic model_edge();
    bit acc;
    acc = id_valid && (m_stall == 0) && !movzres;
    if (id_valid && id_md_start && m_stall == 0)
      busy_until = cyc + 1 + (id_md_div ? 10 : 5);
    hw[2] = hw[1]; ht[2] = ht[1];
    hw[1] = hw[0]; ht[1] = ht[0];
    hw[0] = acc ? int'(id_wa)   : 0;
    ht[0] = acc ? int'(id_tnew) : 0;
    cyc++;
  endtask

  task automatic step(input logic rst, input logic v,
                      input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] rt, input logic [1:0] trt,
                      input logic [4:0] wa, input logic [1:0] tn,
                      input logic md, input logic ms, input logic mdiv, input logic mz,
                      output int s_o, output int f1_o, output int f2_o, output int b_o);
    @(negedge clk);
    reset = rst; id_valid = v; id_rs = rs; id_tuse_rs = trs; id_rt = rt; id_tuse_rt = trt;
    id_wa = wa; id_tnew = tn; id_is_md = md; id_md_start = ms; id_md_div = mdiv; movzres = mz;
    if (!rst) model_clear();
    #1;
    model_eval();
    check_eq("stall",   int'(stall),   m_stall);
    check_eq("fwd_d1",  int'(fwd_d1),  m_f1);
    check_eq("fwd_d2",  int'(fwd_d2),  m_f2);
    check_eq("md_busy", int'(md_busy), m_busy);
    s_o = int'(stall); f1_o = int'(fwd_d1); f2_o = int'(fwd_d2); b_o = int'(md_busy);
    @(posedge clk);
    if (rst) model_edge();
  endtask

  task automatic op(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                    input logic [4:0] rt, input logic [1:0] trt,
                    input logic [4:0] wa, input logic [1:0] tn,
                    output int s, output int f1, output int f2);
    int b;
    step(1'b1, v, rs, trs, rt, trt, wa, tn, 1'b0, 1'b0, 1'b0, 1'b0, s, f1, f2, b);
  endtask

  task automatic flush();
    int s, f1, f2;
    repeat (3) op(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
  endtask

  initial begin
    int s, f1, f2, b, ns, nb;
    logic [1:0] tsel [3];
    tsel[0] = 2'd0; tsel[1] = 2'd1; tsel[2] = 2'd3;
    reset = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3;
    id_wa = '0; id_tnew = 2'd1; id_is_md = 1'b0; id_md_start = 1'b0; id_md_div = 1'b0; movzres = 1'b0;
    model_clear();

    // reset held with arbitrary inputs
    repeat (3) begin
      step(1'b0, 1'b1, 5'($urandom), 2'd0, 5'($urandom), 2'd0, 5'($urandom), 2'd2,
           1'b1, 1'b1, 1'b1, 1'b0, s, f1, f2, b);
      check_eq("rst_stall", s, 0);
      check_eq("rst_fwd1", f1, 0);
      check_eq("rst_fwd2", f2, 0);
      check_eq("rst_busy", b, 0);
    end
    flush();

    // ALU -> beq
    op(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1, s, f1, f2);
    op(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
    check_eq("alu_beq_stall1", s, 1);
    op(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
    check_eq("alu_beq_stall2", s, 0);
    check_eq("alu_beq_fwd1", f1, 1);
    flush();

    // lw -> beq
    op(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2, s, f1, f2);
    op(1'b1, 5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd1, s, f1, f2);
    check_eq("lw_beq_stall1", s, 1);
    op(1'b1, 5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd1, s, f1, f2);
    check_eq("lw_beq_stall2", s, 1);
    op(1'b1, 5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd1, s, f1, f2);
    check_eq("lw_beq_stall3", s, 0);
    check_eq("lw_beq_fwd2", f2, 2);
    flush();

    // lw -> addu (EX user)
    op(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2, s, f1, f2);
    op(1'b1, 5'd9, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, s, f1, f2);
    check_eq("lw_addu_stall1", s, 1);
    op(1'b1, 5'd9, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, s, f1, f2);
    check_eq("lw_addu_stall2", s, 0);
    flush();

    // $0 writer never matches
    op(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
    op(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd1, s, f1, f2);
    check_eq("zero_stall", s, 0);
    check_eq("zero_fwd1", f1, 0);
    flush();

    // MEM beats WB
    op(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, s, f1, f2);
    op(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, s, f1, f2);
    op(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
    op(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
    check_eq("prio_stall", s, 0);
    check_eq("prio_fwd1", f1, 1);
    flush();

    // movz cancelled
    step(1'b1, 1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, s, f1, f2, b);
    op(1'b1, 5'd4, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
    check_eq("movz_stall", s, 0);
    check_eq("movz_fwd1a", f1, 0);
    op(1'b1, 5'd4, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, s, f1, f2);
    check_eq("movz_fwd1b", f1, 0);
    flush();

    // div start, then mfhi held until the counter drains
    step(1'b1, 1'b1, 5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, s, f1, f2, b);
    check_eq("div_start_stall", s, 0);
    ns = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, s, f1, f2, b);
      ns += s;
      nb += b;
      if (s == 0) break;
    end
    check_eq("div_stall_cycles", ns, 10);
    check_eq("div_busy_cycles", nb, 10);
    flush();

    // reset mid-count
    step(1'b1, 1'b1, 5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, s, f1, f2, b);
    step(1'b1, 1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, s, f1, f2, b);
    check_eq("mult_busy", b, 1);
    check_eq("mfhi_stall", s, 1);
    step(1'b0, 1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, s, f1, f2, b);
    check_eq("midrst_busy", b, 0);
    check_eq("midrst_stall", s, 0);
    step(1'b1, 1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, s, f1, f2, b);
    check_eq("postrst_stall", s, 0);

    // random traffic over a small register set to provoke collisions
    for (int i = 0; i < 600; i++) begin
      logic ms, md;
      ms = ($urandom_range(0, 19) == 0);
      md = ms | ($urandom_range(0, 9) == 0);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 6) != 0),
           5'($urandom_range(0, 3)), tsel[$urandom_range(0, 2)],
           5'($urandom_range(0, 3)), tsel[$urandom_range(0, 2)],
           5'($urandom_range(0, 3)), 2'($urandom_range(1, 2)),
           md, ms, 1'($urandom), ($urandom_range(0, 6) == 0), s, f1, f2, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
